// File: rtl/serial_frame_rx.sv
// Serial frame receiver: assembles 8-bit frames from (sin, bit_idx) pairs with framing checks.
// Define RX_PATTERN_CHECK_EN to compare each byte against the sel-derived pattern.
module serial_frame_rx (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       sin,
    input  logic [2:0] bit_idx,
    input  logic [2:0] sel,
    input  logic       byte_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       match,
    output logic [7:0] err_count,
    output logic       overrun,
    output logic [1:0] state
);

`ifdef RX_PATTERN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_HUNT     = 2'b01,
        S_ASSEMBLE = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    exp_idx_q, exp_idx_d;
    logic [BYTE_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]    sel_cap_q, sel_cap_d;
    logic [BYTE_W-1:0]   byte_out_q, byte_out_d;
    logic                byte_valid_q, byte_valid_d;
    logic                match_q, match_d;
    logic [BYTE_W-1:0]   err_count_q, err_count_d;
    logic                overrun_q, overrun_d;

    logic                frame_done;
    logic                err_inc;
    logic                pat_hit;
    logic [BYTE_W-1:0]   new_byte;
    logic [BYTE_W-1:0]   pattern;

    always_comb begin
        state_d      = state_q;
        exp_idx_d    = exp_idx_q;
        shreg_d      = shreg_q;
        sel_cap_d    = sel_cap_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        match_d      = match_q;
        err_count_d  = err_count_q;
        overrun_d    = overrun_q;
        frame_done   = 1'b0;
        err_inc      = 1'b0;
        new_byte     = {sin, shreg_q[6:0]};
        pattern      = 8'hFF >> (3'd7 - sel_cap_q);
        pat_hit      = CHK_EN && (new_byte == pattern);

        // Frame assembly; dropping en abandons any partial frame.
        if (!en) begin
            state_d   = S_IDLE;
            exp_idx_d = '0;
            shreg_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_HUNT;
                S_HUNT: begin
                    if (bit_idx == 3'd0) begin
                        shreg_d   = {7'd0, sin};
                        sel_cap_d = sel;
                        exp_idx_d = 3'd1;
                        state_d   = S_ASSEMBLE;
                    end
                end
                S_ASSEMBLE: begin
                    if (bit_idx == exp_idx_q) begin
                        exp_idx_d = exp_idx_q + 3'd1;
                        if (bit_idx == 3'd0) begin
                            shreg_d   = {7'd0, sin};
                            sel_cap_d = sel;
                        end else begin
                            shreg_d[bit_idx] = sin;
                        end
                        frame_done = (bit_idx == 3'd7);
                    end else begin
                        err_inc   = 1'b1;
                        shreg_d   = '0;
                        exp_idx_d = '0;
                        state_d   = S_HUNT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Output handoff: a completed frame is dropped only if the held byte is still unconsumed.
        if (frame_done) begin
            if (byte_valid_q && !byte_ready) begin
                overrun_d = 1'b1;
            end else begin
                byte_out_d   = new_byte;
                byte_valid_d = 1'b1;
                match_d      = pat_hit;
                if (CHK_EN && !pat_hit) err_inc = 1'b1;
            end
        end else if (byte_valid_q && byte_ready) begin
            byte_valid_d = 1'b0;
        end

        if (err_inc && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            exp_idx_q    <= '0;
            shreg_q      <= '0;
            sel_cap_q    <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            match_q      <= 1'b0;
            err_count_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_idx_q    <= exp_idx_d;
            shreg_q      <= shreg_d;
            sel_cap_q    <= sel_cap_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            match_q      <= match_d;
            err_count_q  <= err_count_d;
            overrun_q    <= overrun_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign match      = match_q;
    assign err_count  = err_count_q;
    assign overrun    = overrun_q;
    assign state      = state_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: directed frames, framing errors, overrun, reset, saturation.
module tb_serial_frame_rx;

`ifdef RX_PATTERN_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       sin;
    logic [2:0] bit_idx;
    logic [2:0] sel;
    logic       byte_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       match;
    logic [7:0] err_count;
    logic       overrun;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;
    int exp_err = 0;
    logic [8:0] exp_q[$];

    serial_frame_rx dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .sin        (sin),
        .bit_idx    (bit_idx),
        .sel        (sel),
        .byte_ready (byte_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .match      (match),
        .err_count  (err_count),
        .overrun    (overrun),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic [2:0] idx, input logic b, input logic [2:0] s);
        bit_idx = idx;
        sin     = b;
        sel     = s;
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [2:0] s);
        for (int i = 0; i < 8; i++) drive_bit(3'(i), data[i], s);
    endtask

    function automatic logic exp_match(input logic [7:0] data, input logic [2:0] s);
        logic [7:0] pat;
        pat = 8'((9'd1 << (s + 3'd1)) - 9'd1);
        return (CHK != 0) && (data == pat);
    endfunction

    task automatic expect_byte(input logic [7:0] data, input logic [2:0] s);
        exp_q.push_back({data, exp_match(data, s)});
        if (CHK != 0 && !exp_match(data, s)) exp_err++;
    endtask

    // Monitor: a fresh byte is one whose valid was low or handshaken at the previous sample.
    initial begin
        logic prev_v, prev_r;
        logic [8:0] e;
        prev_v = 1'b0;
        prev_r = 1'b0;
        forever begin
            @(negedge clock);
            if (byte_valid && (!prev_v || prev_r)) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got %0h expected none", byte_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_out", 32'(byte_out), 32'(e[8:1]));
                    chk("match", 32'(match), 32'(e[0]));
                end
            end
            prev_v = byte_valid;
            prev_r = byte_ready;
        end
    end

    initial begin
        logic [7:0] pat;
        reset = 1'b0; en = 1'b0; sin = 1'b0; bit_idx = '0; sel = '0; byte_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_byte_out", 32'(byte_out), 32'd0);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_match", 32'(match), 32'd0);

        // Single frame 0x0F, sel 3
        reset = 1'b1; en = 1'b1; byte_ready = 1'b1;
        @(posedge clock); #1;
        chk("hunt_after_en", 32'(state), 32'd1);
        expect_byte(8'h0F, 3'd3);
        send_frame(8'h0F, 3'd3);
        chk("f0_valid", 32'(byte_valid), 32'd1);
        chk("f0_state", 32'(state), 32'd2);
        en = 1'b0;
        @(posedge clock); #1;
        chk("f0_valid_cleared", 32'(byte_valid), 32'd0);
        chk("f0_idle", 32'(state), 32'd0);
        chk("f0_err", 32'(err_count), 32'(exp_err));

        // Eight back-to-back pattern frames
        en = 1'b1;
        @(posedge clock); #1;
        for (int s = 0; s < 8; s++) begin
            pat = 8'hFF >> (7 - s);
            expect_byte(pat, 3'(s));
            send_frame(pat, 3'(s));
            chk("b2b_state", 32'(state), 32'd2);
        end
        chk("b2b_err", 32'(err_count), 32'(exp_err));

        // Framing error 0,1,2,4 then a clean frame
        drive_bit(3'd0, 1'b1, 3'd0);
        drive_bit(3'd1, 1'b1, 3'd0);
        drive_bit(3'd2, 1'b1, 3'd0);
        drive_bit(3'd4, 1'b1, 3'd0);
        exp_err++;
        chk("ferr_count", 32'(err_count), 32'(exp_err));
        chk("ferr_state", 32'(state), 32'd1);
        chk("ferr_no_valid", 32'(byte_valid), 32'd0);
        expect_byte(8'hA5, 3'd7);
        send_frame(8'hA5, 3'd7);
        chk("ferr_recover_err", 32'(err_count), 32'(exp_err));

        // Overrun: second frame arrives while first is still held
        expect_byte(8'h3C, 3'd5);
        drive_bit(3'd0, 1'b0, 3'd5);
        byte_ready = 1'b0;
        for (int i = 1; i < 8; i++) drive_bit(3'(i), pat_bit(8'h3C, i), 3'd5);
        send_frame(8'hC3, 3'd1);
        chk("ovr_byte_held", 32'(byte_out), 32'h3C);
        chk("ovr_valid", 32'(byte_valid), 32'd1);
        chk("ovr_flag", 32'(overrun), 32'd1);
        byte_ready = 1'b1; en = 1'b0;
        @(posedge clock); #1;
        chk("ovr_consumed", 32'(byte_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_err", 32'(err_count), 32'(exp_err));

        // sel 2 with data 0x03: pattern mismatch
        en = 1'b1;
        @(posedge clock); #1;
        expect_byte(8'h03, 3'd2);
        send_frame(8'h03, 3'd2);
        chk("pat_match", 32'(match), 32'd0);
        chk("pat_err", 32'(err_count), 32'(exp_err));

        // Asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) drive_bit(3'(i), 1'b1, 3'd0);
        bit_idx = 3'd4;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_byte_out", 32'(byte_out), 32'd0);
        chk("mid_rst_valid", 32'(byte_valid), 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_match", 32'(match), 32'd0);
        exp_err = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_hunt", 32'(state), 32'd1);
        drive_bit(3'd5, 1'b1, 3'd0);
        drive_bit(3'd6, 1'b1, 3'd0);
        drive_bit(3'd7, 1'b1, 3'd0);
        chk("post_rst_still_hunt", 32'(state), 32'd1);
        chk("post_rst_no_err", 32'(err_count), 32'd0);
        expect_byte(8'h01, 3'd0);
        send_frame(8'h01, 3'd0);
        chk("post_rst_err", 32'(err_count), 32'(exp_err));

        // Saturation: 300 framing errors
        for (int n = 1; n <= 300; n++) begin
            drive_bit(3'd0, 1'b1, 3'd0);
            drive_bit(3'd2, 1'b0, 3'd0);
            if (n == 100) chk("sat_err_100", 32'(err_count), 32'd100);
        end
        chk("sat_err", 32'(err_count), 32'hFF);
        chk("sat_state", 32'(state), 32'd1);

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic pat_bit(input logic [7:0] data, input int i);
        return data[i];
    endfunction

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL: clock  input  1  rising-edge system clock.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: en  input  1  receive enable; 0 forces IDLE.
REQ-004 SHALL: sin  input  1  serial data bit from the upstream bit-mux stage.
REQ-005 SHALL: bit_idx  input  3  frame position of sin (upstream 3-bit counter value).
REQ-006 SHALL: sel  input  3  pattern index in use upstream; expected byte = (1 << (sel+1)) - 1, i.e. 8'h01..8'hFF.
REQ-007 SHALL: byte_ready  input  1  consumer accepts byte_out.
REQ-008 SHALL: byte_out  output  8  assembled byte, bit i = sin sampled at bit_idx == i.
REQ-009 SHALL: byte_valid  output  1  byte_out holds an unconsumed byte.
REQ-010 SHALL: match  output  1  byte_out equals the expected pattern for the sel captured at that frame's bit 0.
REQ-011 SHALL: err_count  output  8  saturating error counter.
REQ-012 SHALL: overrun  output  1  sticky flag, a completed frame was dropped.
REQ-013 SHALL: state  output  2  FSM state: 00 IDLE, 01 HUNT, 10 ASSEMBLE.

Function
REQ-014 SHALL: all state updates occur on the rising clock edge; all outputs are registered.
REQ-015 SHALL: IDLE -> HUNT when en == 1; any state -> IDLE when en == 0, discarding the partial frame; byte_out, byte_valid, err_count and overrun are retained.
REQ-016 SHALL: HUNT: when bit_idx == 0, store sin as bit 0, capture sel, set exp_idx = 1, go to ASSEMBLE; otherwise remain in HUNT with no error counted.
REQ-017 SHALL: ASSEMBLE with bit_idx == exp_idx: store sin at bit position bit_idx, exp_idx increments modulo 8.
REQ-018 SHALL: ASSEMBLE with bit_idx != exp_idx: framing error, partial frame discarded, err_count += 1, go to HUNT.
REQ-019 SHALL: frame completes at the edge sampling bit_idx == 7; byte_out/match/byte_valid are updated at that same edge (visible one cycle after bit 7 is presented).
REQ-020 SHALL: after completion, remain in ASSEMBLE expecting bit_idx == 0, where sel is re-captured; back-to-back frames therefore need no HUNT cycle.
REQ-021 SHALL: byte_valid clears at an edge where byte_ready == 1, unless a frame completes at the same edge, in which case the new byte loads and byte_valid stays 1.
REQ-022 SHALL: if a frame completes while byte_valid == 1 and byte_ready == 0, the new byte is dropped, byte_out is unchanged and overrun is set to 1.
REQ-023 SHALL: err_count saturates at 8'hFF; multiple error sources in one cycle add 1 only.
REQ-024 SHALL: byte_ready is ignored when byte_valid == 0.

Reset
REQ-025 SHALL: reset == 0 immediately forces state = IDLE, exp_idx = 0, shift register = 8'h00, byte_out = 8'h00, byte_valid = 0, match = 0, err_count = 8'h00, overrun = 0.
REQ-026 SHALL: reset asserted mid-frame discards the frame; after release with en == 1, the first valid frame starts at the next bit_idx == 0.

Configuration
REQ-027 SHALL: with macro RX_PATTERN_CHECK_EN defined, match is computed and each accepted frame with match == 0 increments err_count.
REQ-028 SHALL: without RX_PATTERN_CHECK_EN, match is constant 0 and err_count counts framing errors only; all other behaviour is unchanged.

Verification
REQ-029 SHALL: reset low 2 cycles, en = 1, bit_idx 0..7 with sin = bits of 8'h0F, sel = 3, byte_ready = 1 -> byte_out = 8'h0F, match = 1, byte_valid high 1 cycle, err_count = 0.
REQ-030 SHALL: 8 consecutive frames with sel = 0..7 and matching data -> bytes 8'h01..8'hFF, no HUNT between frames, err_count = 0.
REQ-031 SHALL: bit_idx sequence 0,1,2,4 -> framing error, err_count = 1, state = HUNT, no byte_valid; the next clean frame is received correctly.
REQ-032 SHALL: byte_ready = 0 across two complete frames -> byte_out holds the first byte, overrun = 1; byte_ready = 1 for one cycle then clears byte_valid, overrun stays 1.
REQ-033 SHALL: sel = 2 with data 8'h03 (RX_PATTERN_CHECK_EN defined) -> match = 0, err_count = 1; the same stimulus without the macro -> match = 0, err_count = 0.
REQ-034 SHALL: reset pulsed low at bit_idx = 4, and separately 300 framing errors -> all outputs at reset values; err_count stops at 8'hFF.
